// File: rtl/arbiter_types.sv
// Shared types and constants for the memory-port arbiter and the caches it serves.
package arbiter_types;

    localparam int LINE_W       = 256;
    localparam int ADDR_W       = 32;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive D-side grants made while the I-side waits; saturates at LIMIT.
module arb_starve_counter
    import arbiter_types::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != LIMIT_C)) begin
            count_q <= count_q + STARVE_CNT_W'(1);
        end
    end

    assign at_limit = (count_q == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory line port between I-cache refills and D-cache misses/writebacks,
// favouring D-side while guaranteeing I-side progress through a starvation limit.
module mem_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_WIDTH   = LINE_W,
    parameter int ADDR_WIDTH   = ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  grant_d
);

    arb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  write_q;

    logic d_req, pick_d, pick_i;
    logic starve_at_limit, cnt_inc, cnt_clr;
    logic serving;

    assign d_req = d_read | d_write;

    always_comb begin
        state_d = state_q;
        pick_d  = 1'b0;
        pick_i  = 1'b0;
        case (state_q)
            IDLE: begin
                // D wins unless I has already been passed over STARVE_LIMIT times
                pick_d = d_req && !(i_read && starve_at_limit);
                pick_i = !pick_d && i_read;
                if (pick_d) begin
                    state_d = SERVE_D;
                end else if (pick_i) begin
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request is captured at grant so requesters may not disturb an in-flight transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else if (pick_d) begin
            addr_q  <= d_address;
            write_q <= d_write;
            if (d_write) begin
                wdata_q <= d_wdata;
            end
        end else if (pick_i) begin
            addr_q  <= i_address;
            write_q <= 1'b0;
        end
    end

    assign cnt_inc = pick_d & i_read;
    assign cnt_clr = (pick_d & ~i_read) | pick_i;

    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .at_limit(starve_at_limit)
    );

    assign serving     = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign mem_read    = serving & ~write_q;
    assign mem_write   = serving & write_q;
    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;
    assign grant_d     = (state_q == SERVE_D);

    assign i_resp  = (state_q == SERVE_I) & mem_resp;
    assign d_resp  = (state_q == SERVE_D) & mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-side traffic, priority, write latching,
// starvation guard, asynchronous reset and stray memory responses.
module tb_mem_arbiter;
    import arbiter_types::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;
    logic          grant_d;

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter #(
        .LINE_WIDTH  (LW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .grant_d    (grant_d)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [LW-1:0] line_a5, line_cafe, line_wr, line_5a;

    initial begin
        line_a5   = {32{8'hA5}};
        line_cafe = {8{32'hCAFE_F00D}};
        line_wr   = {8{32'h1234_5678}};
        line_5a   = {16{16'h5A3C}};

        rst_n = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_mem_read",  LW'(mem_read),    LW'(0));
        check("rst_mem_write", LW'(mem_write),   LW'(0));
        check("rst_grant_d",   LW'(grant_d),     LW'(0));
        check("rst_resp",      LW'({i_resp, d_resp}), LW'(0));
        check("rst_addr",      LW'(mem_address), LW'(0));
        check("rst_wdata",     mem_wdata,        LW'(0));
        check("rst_state",     LW'(dut.state_q), LW'(IDLE));
        check("rst_cnt",       LW'(dut.u_starve.count_q), LW'(0));
        step();
        rst_n = 1'b1;

        // I-side only
        i_read = 1'b1; i_address = 32'h0000_1040;
        step();
        @(negedge clk);
        check("i_mem_read", LW'(mem_read),    LW'(1));
        check("i_addr",     LW'(mem_address), LW'(32'h0000_1040));
        check("i_grant_d",  LW'(grant_d),     LW'(0));
        check("i_early",    LW'(i_resp),      LW'(0));
        step();
        step();
        mem_resp = 1'b1; mem_rdata = line_a5;
        @(negedge clk);
        check("i_resp",  LW'(i_resp), LW'(1));
        check("i_rdata", i_rdata,     line_a5);
        check("i_dresp", LW'(d_resp), LW'(0));
        step();
        mem_resp = 1'b0; i_read = 1'b0;
        @(negedge clk);
        check("i_done_rd",   LW'(mem_read), LW'(0));
        check("i_done_resp", LW'(i_resp),   LW'(0));
        step();

        // simultaneous requests: D first, then I
        i_read = 1'b1; i_address = 32'h0000_2080;
        d_read = 1'b1; d_address = 32'h0000_4000;
        step();
        @(negedge clk);
        check("sim_grant_d", LW'(grant_d),     LW'(1));
        check("sim_d_read",  LW'(mem_read),    LW'(1));
        check("sim_d_addr",  LW'(mem_address), LW'(32'h0000_4000));
        check("sim_cnt1",    LW'(dut.u_starve.count_q), LW'(1));
        step();
        mem_resp = 1'b1; mem_rdata = line_cafe;
        @(negedge clk);
        check("sim_d_resp", LW'(d_resp), LW'(1));
        check("sim_i_hold", LW'(i_resp), LW'(0));
        check("sim_d_data", d_rdata,     line_cafe);
        step();
        mem_resp = 1'b0; d_read = 1'b0;
        @(negedge clk);
        check("sim_done_rd", LW'(mem_read), LW'(0));
        check("sim_done_g",  LW'(grant_d),  LW'(0));
        step();
        @(negedge clk);
        check("sim_idle_rd", LW'(mem_read), LW'(0));
        step();
        @(negedge clk);
        check("sim_i_read",  LW'(mem_read),    LW'(1));
        check("sim_i_grant", LW'(grant_d),     LW'(0));
        check("sim_i_addr",  LW'(mem_address), LW'(32'h0000_2080));
        check("sim_cnt0",    LW'(dut.u_starve.count_q), LW'(0));
        step();
        mem_resp = 1'b1;
        @(negedge clk);
        check("sim_i_resp", LW'(i_resp), LW'(1));
        step();
        mem_resp = 1'b0; i_read = 1'b0;
        step();

        // D write with inputs disturbed mid-transaction
        d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = line_wr;
        step();
        @(negedge clk);
        check("wr_mem_write", LW'(mem_write),   LW'(1));
        check("wr_mem_read",  LW'(mem_read),    LW'(0));
        check("wr_addr",      LW'(mem_address), LW'(32'h8000_0020));
        check("wr_wdata",     mem_wdata,        line_wr);
        step();
        d_address = 32'hDEAD_BEEC; d_wdata = ~line_wr;
        @(negedge clk);
        check("wr_addr_hold",  LW'(mem_address), LW'(32'h8000_0020));
        check("wr_wdata_hold", mem_wdata,        line_wr);
        step();
        mem_resp = 1'b1;
        @(negedge clk);
        check("wr_resp",      LW'(d_resp),    LW'(1));
        check("wr_wr_at_rsp", LW'(mem_write), LW'(1));
        check("wr_wdata_rsp", mem_wdata,      line_wr);
        step();
        mem_resp = 1'b0; d_write = 1'b0;
        @(negedge clk);
        check("wr_resp_once", LW'(d_resp),    LW'(0));
        check("wr_done_wr",   LW'(mem_write), LW'(0));
        step();

        // starvation guard: four D grants then I
        i_read = 1'b1; i_address = 32'h0000_5000;
        d_read = 1'b1; d_address = 32'h0000_6000;
        for (int g = 0; g < 5; g++) begin
            step();
            mem_resp = 1'b1;
            @(negedge clk);
            check($sformatf("stv_grant%0d", g), LW'(grant_d), LW'(g < 4));
            check($sformatf("stv_addr%0d", g), LW'(mem_address),
                  (g < 4) ? LW'(32'h0000_6000) : LW'(32'h0000_5000));
            check($sformatf("stv_cnt%0d", g), LW'(dut.u_starve.count_q),
                  (g < 4) ? LW'(g + 1) : LW'(0));
            check($sformatf("stv_resp%0d", g), LW'({i_resp, d_resp}),
                  (g < 4) ? LW'(2'b01) : LW'(2'b10));
            step();
            mem_resp = 1'b0;
            if (g == 4) begin
                i_read = 1'b0; d_read = 1'b0;
            end
            step();
        end

        // asynchronous reset in the middle of a D transaction
        d_read = 1'b1; d_address = 32'h0000_7000;
        step();
        @(negedge clk);
        check("rmid_grant", LW'(grant_d), LW'(1));
        #2;
        rst_n = 1'b0; mem_resp = 1'b1;
        #1;
        check("rmid_grant_off", LW'(grant_d),   LW'(0));
        check("rmid_rd_off",    LW'(mem_read),  LW'(0));
        check("rmid_wr_off",    LW'(mem_write), LW'(0));
        check("rmid_no_resp",   LW'({i_resp, d_resp}), LW'(0));
        step();
        mem_resp = 1'b0; d_read = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rmid_state", LW'(dut.state_q), LW'(IDLE));
        i_read = 1'b1; i_address = 32'h0000_3000;
        step();
        @(negedge clk);
        check("rmid_i_read",  LW'(mem_read),    LW'(1));
        check("rmid_i_addr",  LW'(mem_address), LW'(32'h0000_3000));
        check("rmid_i_grant", LW'(grant_d),     LW'(0));
        step();
        mem_resp = 1'b1; mem_rdata = line_5a;
        @(negedge clk);
        check("rmid_i_resp", LW'(i_resp), LW'(1));
        check("rmid_i_data", i_rdata,     line_5a);
        step();
        mem_resp = 1'b0; i_read = 1'b0;
        step();

        // stray mem_resp while idle
        mem_resp = 1'b1;
        @(negedge clk);
        check("stray_resp", LW'({i_resp, d_resp}), LW'(0));
        step();
        mem_resp = 1'b0;
        @(negedge clk);
        check("stray_state", LW'(dut.state_q), LW'(IDLE));
        check("stray_rd",    LW'(mem_read),    LW'(0));
        i_read = 1'b1; i_address = 32'h0000_0100;
        step();
        @(negedge clk);
        check("stray_next_rd", LW'(mem_read), LW'(1));
        step();
        mem_resp = 1'b1;
        step();
        mem_resp = 1'b0; i_read = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
